ws2812_rx_decoder: RTL and testbench

//  Receive-side decoder for the single-wire WS2812 LED-strip protocol our strip driver emits.

---
 rtl/ws2812_rx_decoder.sv | 235 +++++++++++++++++++++++
 tb/tb_ws2812_rx_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx_decoder.sv
// ws2812_rx_decoder
//   Receive-side decoder for the single-wire WS2812 LED-strip protocol.
//   The serial line is oversampled with clk_i, and each bit is classified by
//   the width of its high pulse. The decoder assembles MSB-first 24-bit
//   pixel words and strobes frame boundaries (a long low gap) and protocol
//   errors.
//
// Ports
//   clk_i           system clock
//   rst_i           asynchronous active-high reset
//   din_i           WS2812 serial line, asynchronous to clk_i
//   pixel_data_o    last decoded pixel; the first received bit is in [23]
//   pixel_valid_o   one-cycle strobe; pixel_data_o/pixel_index_o are valid
//   pixel_index_o   index of the pixel within the frame
//   frame_done_o    one-cycle strobe at the end-of-frame gap
//   frame_pixels_o  whole pixels received in the frame (valid with frame_done_o)
//   err_o           one-cycle error strobe
//   err_code_o      0 short high, 1 long high, 2 partial pixel, 3 pixel overflow
//   in_frame_o      high while a frame is being received
module ws2812_rx_decoder #(
  parameter int  MAX_PIXELS    = 160,
  parameter int  MIN_HIGH      = 5,
  parameter int  ONE_THRESHOLD = 35,
  parameter int  MAX_HIGH      = 65,
  parameter int  RESET_CYCLES  = 2500,
  localparam int IW            = $clog2(MAX_PIXELS),
  localparam int FW            = $clog2(MAX_PIXELS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          din_i,
  output logic [23:0]   pixel_data_o,
  output logic          pixel_valid_o,
  output logic [IW-1:0] pixel_index_o,
  output logic          frame_done_o,
  output logic [FW-1:0] frame_pixels_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic          in_frame_o
);

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);

  localparam logic [HW-1:0] HI_MIN  = HW'(MIN_HIGH);
  localparam logic [HW-1:0] HI_ONE  = HW'(ONE_THRESHOLD);
  localparam logic [HW-1:0] HI_MAX  = HW'(MAX_HIGH);
  localparam logic [HW-1:0] HI_SAT  = HW'(MAX_HIGH + 1);
  localparam logic [LW-1:0] LO_SAT  = LW'(RESET_CYCLES);
  localparam logic [FW-1:0] PIX_MAX = FW'(MAX_PIXELS);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t state_q, state_d;

  logic          sync_q, din_s_q, din_d_q;
  logic [HW-1:0] high_cnt_q, high_cnt_d;
  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] pix_cnt_q, pix_cnt_d;
  logic          ovf_q, ovf_d;
  logic [23:0]   shift_q, shift_d;

  logic [23:0]   pixel_data_q, pixel_data_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic [IW-1:0] pixel_index_q, pixel_index_d;
  logic          frame_done_q, frame_done_d;
  logic [FW-1:0] frame_pixels_q, frame_pixels_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          in_frame_q, in_frame_d;

  logic          rise, fall, bit_val, short_hi, long_hi, gap_done;
  logic [23:0]   shifted;

  assign rise     = din_s_q & ~din_d_q;
  assign fall     = ~din_s_q & din_d_q;
  // On the falling-edge cycle, high_cnt_q holds the full width of the pulse that just ended.
  assign short_hi = fall && (high_cnt_q < HI_MIN);
  assign long_hi  = high_cnt_q > HI_MAX;
  assign gap_done = low_cnt_q == LO_SAT;
  assign bit_val  = high_cnt_q >= HI_ONE;
  assign shifted  = {shift_q[22:0], bit_val};

  // Each counter clears while the line sits at the opposite level, so it
  // starts from zero at every edge and saturates instead of wrapping.
  always_comb begin
    high_cnt_d = '0;
    low_cnt_d  = '0;
    if (din_s_q) begin
      high_cnt_d = (high_cnt_q != HI_SAT) ? high_cnt_q + 1'b1 : high_cnt_q;
    end else begin
      low_cnt_d = (low_cnt_q != LO_SAT) ? low_cnt_q + 1'b1 : low_cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC: if (gap_done) state_d = IDLE;
      IDLE: if (rise) state_d = HIGH;
      HIGH: begin
        if (short_hi || long_hi) state_d = SYNC;
        else if (fall)           state_d = LOW;
      end
      LOW: begin
        if (gap_done)  state_d = IDLE;
        else if (rise) state_d = HIGH;
      end
      default: state_d = SYNC;
    endcase
  end

  // The overflow error fires only on the first surplus pixel. Decoding then
  // continues, so the frame still ends with frame_done and MAX_PIXELS.
  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    pix_cnt_d      = pix_cnt_q;
    ovf_d          = ovf_q;
    shift_d        = shift_q;
    pixel_data_d   = pixel_data_q;
    pixel_index_d  = pixel_index_q;
    frame_pixels_d = frame_pixels_q;
    err_code_d     = err_code_q;
    in_frame_d     = in_frame_q;
    pixel_valid_d  = 1'b0;
    frame_done_d   = 1'b0;
    err_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          in_frame_d = 1'b1;
          bit_cnt_d  = '0;
          pix_cnt_d  = '0;
          ovf_d      = 1'b0;
        end
      end
      HIGH: begin
        if (short_hi || long_hi) begin
          err_d      = 1'b1;
          err_code_d = short_hi ? 2'd0 : 2'd1;
          in_frame_d = 1'b0;
          bit_cnt_d  = '0;
        end else if (fall) begin
          shift_d = shifted;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            if (pix_cnt_q < PIX_MAX) begin
              pixel_data_d  = shifted;
              pixel_index_d = pix_cnt_q[IW-1:0];
              pixel_valid_d = 1'b1;
              pix_cnt_d     = pix_cnt_q + 1'b1;
            end else if (!ovf_q) begin
              err_d      = 1'b1;
              err_code_d = 2'd3;
              ovf_d      = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      LOW: begin
        if (gap_done) begin
          frame_done_d   = 1'b1;
          frame_pixels_d = pix_cnt_q;
          in_frame_d     = 1'b0;
          bit_cnt_d      = '0;
          if (bit_cnt_q != 5'd0) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end
        end
      end
      default: ;
    endcase
  end

  // din_i passes through two synchroniser flops before use; din_d_q lags
  // din_s_q by one cycle for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q         <= 1'b0;
      din_s_q        <= 1'b0;
      din_d_q        <= 1'b0;
      high_cnt_q     <= '0;
      low_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      pix_cnt_q      <= '0;
      ovf_q          <= 1'b0;
      shift_q        <= '0;
      pixel_data_q   <= '0;
      pixel_valid_q  <= 1'b0;
      pixel_index_q  <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      err_q          <= 1'b0;
      err_code_q     <= '0;
      in_frame_q     <= 1'b0;
    end else begin
      sync_q         <= din_i;
      din_s_q        <= sync_q;
      din_d_q        <= din_s_q;
      high_cnt_q     <= high_cnt_d;
      low_cnt_q      <= low_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      pix_cnt_q      <= pix_cnt_d;
      ovf_q          <= ovf_d;
      shift_q        <= shift_d;
      pixel_data_q   <= pixel_data_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_index_q  <= pixel_index_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      in_frame_q     <= in_frame_d;
    end
  end

  assign pixel_data_o   = pixel_data_q;
  assign pixel_valid_o  = pixel_valid_q;
  assign pixel_index_o  = pixel_index_q;
  assign frame_done_o   = frame_done_q;
  assign frame_pixels_o = frame_pixels_q;
  assign err_o          = err_q;
  assign err_code_o     = err_code_q;
  assign in_frame_o     = in_frame_q;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// tb_ws2812_rx_decoder
//   Directed bench for ws2812_rx_decoder. The DUT is built with a small
//   pixel limit so that the full-frame and overflow cases stay short.
//   Bits are driven with driver timing: a 1 is 50 cycles high and 20 low,
//   and a 0 is 20 cycles high and 50 low.
module tb_ws2812_rx_decoder;

  localparam int MAXPIX = 8;
  localparam int IW     = $clog2(MAXPIX);
  localparam int FW     = $clog2(MAXPIX + 1);
  localparam int GAP    = 2520;

  logic          clk, rst, din;
  logic [23:0]   pixel_data_o;
  logic          pixel_valid_o;
  logic [IW-1:0] pixel_index_o;
  logic          frame_done_o;
  logic [FW-1:0] frame_pixels_o;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic          in_frame_o;

  ws2812_rx_decoder #(.MAX_PIXELS(MAXPIX)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .din_i          (din),
    .pixel_data_o   (pixel_data_o),
    .pixel_valid_o  (pixel_valid_o),
    .pixel_index_o  (pixel_index_o),
    .frame_done_o   (frame_done_o),
    .frame_pixels_o (frame_pixels_o),
    .err_o          (err_o),
    .err_code_o     (err_code_o),
    .in_frame_o     (in_frame_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // The strobe monitor samples on the falling clock edge and keeps running
  // tallies. The main sequence clears them through clearMon.
  logic          clearMon = 1'b0;
  int            pvCount, idxBad, errCount, fdCount, errWithFd;
  logic [23:0]   lastData;
  logic [IW-1:0] lastIndex;
  logic [1:0]    lastErrCode;
  logic [FW-1:0] lastFramePixels;

  always @(negedge clk) begin
    if (clearMon) begin
      pvCount         <= 0;
      idxBad          <= 0;
      errCount        <= 0;
      fdCount         <= 0;
      errWithFd       <= 0;
      lastData        <= '0;
      lastIndex       <= '0;
      lastErrCode     <= '0;
      lastFramePixels <= '0;
    end else begin
      if (pixel_valid_o) begin
        if (pixel_index_o != pvCount[IW-1:0]) idxBad <= idxBad + 1;
        pvCount   <= pvCount + 1;
        lastData  <= pixel_data_o;
        lastIndex <= pixel_index_o;
      end
      if (err_o) begin
        errCount    <= errCount + 1;
        lastErrCode <= err_code_o;
        if (frame_done_o) errWithFd <= errWithFd + 1;
      end
      if (frame_done_o) begin
        fdCount         <= fdCount + 1;
        lastFramePixels <= frame_pixels_o;
      end
    end
  end

  task automatic clearMonitor();
    clearMon = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    clearMon = 1'b0;
  endtask

  task automatic holdLevel(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send the top nbits of word, MSB first.
  task automatic applyStimulus(input logic [23:0] word, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) begin
      if (word[i]) begin
        holdLevel(1'b1, 50);
        holdLevel(1'b0, 20);
      end else begin
        holdLevel(1'b1, 20);
        holdLevel(1'b0, 50);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pixel_valid", 32'(pixel_valid_o), 32'd0);
    checkOutput("rst_pixel_data", 32'(pixel_data_o), 32'd0);
    checkOutput("rst_in_frame", 32'(in_frame_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done_o), 32'd0);
    rst = 1'b0;
    holdLevel(1'b0, GAP);
    clearMonitor();

    // Test 1: a single pixel, including exact strobe latency after the last falling edge.
    $display("[TB] test 1: single pixel 0xA53C0F");
    applyStimulus(24'hA53C0F, 23);
    holdLevel(1'b1, 50);
    checkOutput("t1_in_frame", 32'(in_frame_o), 32'd1);
    din = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("t1_pv_early", 32'(pixel_valid_o), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("t1_pv_latency", 32'(pixel_valid_o), 32'd1);
    checkOutput("t1_data", 32'(pixel_data_o), 32'hA53C0F);
    checkOutput("t1_index", 32'(pixel_index_o), 32'd0);
    holdLevel(1'b0, GAP);
    checkOutput("t1_pv_count", pvCount, 32'd1);
    checkOutput("t1_fd_count", fdCount, 32'd1);
    checkOutput("t1_frame_pixels", 32'(lastFramePixels), 32'd1);
    checkOutput("t1_err_count", errCount, 32'd0);
    checkOutput("t1_in_frame_end", 32'(in_frame_o), 32'd0);

    // Test 2: a full frame of alternating pixels.
    $display("[TB] test 2: full frame of %0d pixels", MAXPIX);
    clearMonitor();
    for (int p = 0; p < MAXPIX; p++) applyStimulus((p % 2 == 0) ? 24'hFFFFFF : 24'h000000, 24);
    holdLevel(1'b0, GAP);
    checkOutput("t2_pv_count", pvCount, 32'(MAXPIX));
    checkOutput("t2_idx_seq", idxBad, 32'd0);
    checkOutput("t2_last_index", 32'(lastIndex), 32'(MAXPIX - 1));
    checkOutput("t2_fd_count", fdCount, 32'd1);
    checkOutput("t2_frame_pixels", 32'(lastFramePixels), 32'(MAXPIX));
    checkOutput("t2_err_count", errCount, 32'd0);

    // Test 3: one surplus pixel raises a single overflow error.
    $display("[TB] test 3: overflow by one pixel");
    clearMonitor();
    for (int p = 0; p <= MAXPIX; p++) applyStimulus((p % 2 == 0) ? 24'hFFFFFF : 24'h000000, 24);
    holdLevel(1'b0, GAP);
    checkOutput("t3_pv_count", pvCount, 32'(MAXPIX));
    checkOutput("t3_err_count", errCount, 32'd1);
    checkOutput("t3_err_code", 32'(lastErrCode), 32'd3);
    checkOutput("t3_fd_count", fdCount, 32'd1);
    checkOutput("t3_frame_pixels", 32'(lastFramePixels), 32'(MAXPIX));
    checkOutput("t3_data_kept", 32'(pixel_data_o), 32'h000000);
    checkOutput("t3_err_with_fd", errWithFd, 32'd0);

    // Test 4: a 3-cycle glitch mid-pixel, then resync.
    $display("[TB] test 4: short high pulse");
    clearMonitor();
    applyStimulus(24'hFFC000, 10);
    holdLevel(1'b1, 3);
    holdLevel(1'b0, 10);
    checkOutput("t4_in_frame", 32'(in_frame_o), 32'd0);
    checkOutput("t4_err_count", errCount, 32'd1);
    checkOutput("t4_err_code", 32'(lastErrCode), 32'd0);
    holdLevel(1'b0, GAP);
    checkOutput("t4_no_fd", fdCount, 32'd0);
    checkOutput("t4_no_pv", pvCount, 32'd0);
    applyStimulus(24'h123456, 24);
    holdLevel(1'b0, GAP);
    checkOutput("t4_resync_pv", pvCount, 32'd1);
    checkOutput("t4_resync_data", 32'(lastData), 32'h123456);
    checkOutput("t4_resync_index", 32'(lastIndex), 32'd0);
    checkOutput("t4_resync_fd", fdCount, 32'd1);
    checkOutput("t4_resync_frame_pixels", 32'(lastFramePixels), 32'd1);
    checkOutput("t4_resync_err_count", errCount, 32'd1);

    // Test 5: the line held high reports a long high once high_cnt reaches 66.
    $display("[TB] test 5: long high");
    clearMonitor();
    din = 1'b1;
    repeat (68) @(posedge clk);
    #1;
    checkOutput("t5_err_early", 32'(err_o), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("t5_err_strobe", 32'(err_o), 32'd1);
    checkOutput("t5_err_code", 32'(err_code_o), 32'd1);
    repeat (31) @(posedge clk);
    #1;
    holdLevel(1'b0, 100);
    applyStimulus(24'hFFFFFF, 24);
    holdLevel(1'b0, GAP);
    checkOutput("t5_sync_no_pv", pvCount, 32'd0);
    checkOutput("t5_sync_no_fd", fdCount, 32'd0);
    checkOutput("t5_err_count", errCount, 32'd1);
    checkOutput("t5_in_frame", 32'(in_frame_o), 32'd0);
    checkOutput("t5_err_code_hold", 32'(err_code_o), 32'd1);

    // Test 6a: a partial pixel at the frame gap.
    $display("[TB] test 6: partial pixel and mid-frame reset");
    clearMonitor();
    applyStimulus(24'hABCDEF, 10);
    holdLevel(1'b0, GAP);
    checkOutput("t6_fd_count", fdCount, 32'd1);
    checkOutput("t6_frame_pixels", 32'(lastFramePixels), 32'd0);
    checkOutput("t6_err_count", errCount, 32'd1);
    checkOutput("t6_err_code", 32'(lastErrCode), 32'd2);
    checkOutput("t6_err_with_fd", errWithFd, 32'd1);
    checkOutput("t6_no_pv", pvCount, 32'd0);

    // Test 6b: an asynchronous reset mid-pixel, away from any clock edge.
    applyStimulus(24'h5A5A5A, 5);
    din = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t6_pre_rst_in_frame", 32'(in_frame_o), 32'd1);
    checkOutput("t6_pre_rst_data", 32'(pixel_data_o), 32'h123456);
    #4 rst = 1'b1;
    #1;
    checkOutput("t6_rst_data", 32'(pixel_data_o), 32'd0);
    checkOutput("t6_rst_in_frame", 32'(in_frame_o), 32'd0);
    checkOutput("t6_rst_err_code", 32'(err_code_o), 32'd0);
    checkOutput("t6_rst_pv", 32'(pixel_valid_o), 32'd0);
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    holdLevel(1'b0, GAP);
    clearMonitor();
    applyStimulus(24'h3C5AA5, 24);
    holdLevel(1'b0, GAP);
    checkOutput("t6_clean_pv", pvCount, 32'd1);
    checkOutput("t6_clean_data", 32'(lastData), 32'h3C5AA5);
    checkOutput("t6_clean_index", 32'(lastIndex), 32'd0);
    checkOutput("t6_clean_fd", fdCount, 32'd1);
    checkOutput("t6_clean_frame_pixels", 32'(lastFramePixels), 32'd1);
    checkOutput("t6_clean_err", errCount, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
